// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-master SDRAM user-port arbiter.
// Contents: arbiter state enum, read-queue entry payload, default widths,
// round-robin reset value and the burstcount normalisation helper.
package sdram_arb_pkg;

    localparam int unsigned ARB_AW       = 24;
    localparam int unsigned ARB_DW       = 16;
    localparam int unsigned ARB_BEW      = ARB_DW / 8;
    localparam int unsigned ARB_BCW      = 9;
    localparam int unsigned ARB_MAX_PEND = 4;

    // last_grant after reset: pointing at m1 makes m0 win the first tie
    localparam logic RR_RESET_LAST = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        WBURST = 2'd2
    } arb_state_t;

    // One outstanding read command: issuing master and beats still owed
    typedef struct packed {
        logic               id;
        logic [ARB_BCW-1:0] len;
    } rdq_entry_t;

    // A burstcount of zero is handled as a single beat
    function automatic logic [ARB_BCW-1:0] eff_len(input logic [ARB_BCW-1:0] bc);
        return (bc == '0) ? ARB_BCW'(1) : bc;
    endfunction

endpackage

// File: rtl/sdram_arb_rdq.sv
// Outstanding-read queue: synchronous FIFO of rdq_entry_t.
// Ports: clk/rst_n (async active-low), push/push_data, pop, head (current
// front entry, valid when !empty), full, empty. Push while full and pop
// while empty are ignored; push and pop in one cycle are both honoured.
module sdram_arb_rdq
    import sdram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = ARB_MAX_PEND
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  rdq_entry_t push_data,
    input  logic       pop,
    output rdq_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    rdq_entry_t        mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: contents are only read when count_q says valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/sdram_user_arbiter.sv
// Two-master Avalon-MM arbiter in front of the SDRAM controller user slave.
// Ports: clk_clk, reset_reset_n (async active-low); m0_*/m1_* master slaves
// (address, burstcount, writedata, byteenable, write, read in; waitrequest,
// readdata, readdatavalid out); s_* master port towards the SDRAM slave;
// err_orphan sticky flag for read data returned with nothing outstanding.
// Round-robin grant, write bursts keep the grant, read returns are routed
// back through a queue of {master, length} entries.
module sdram_user_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned AW       = ARB_AW,
    parameter int unsigned DW       = ARB_DW,
    parameter int unsigned BEW      = ARB_BEW,
    parameter int unsigned BCW      = ARB_BCW,
    parameter int unsigned MAX_PEND = ARB_MAX_PEND
) (
    input  logic           clk_clk,
    input  logic           reset_reset_n,

    input  logic [AW-1:0]  m0_address,
    input  logic [BCW-1:0] m0_burstcount,
    input  logic [DW-1:0]  m0_writedata,
    input  logic [BEW-1:0] m0_byteenable,
    input  logic           m0_write,
    input  logic           m0_read,
    output logic           m0_waitrequest,
    output logic [DW-1:0]  m0_readdata,
    output logic           m0_readdatavalid,

    input  logic [AW-1:0]  m1_address,
    input  logic [BCW-1:0] m1_burstcount,
    input  logic [DW-1:0]  m1_writedata,
    input  logic [BEW-1:0] m1_byteenable,
    input  logic           m1_write,
    input  logic           m1_read,
    output logic           m1_waitrequest,
    output logic [DW-1:0]  m1_readdata,
    output logic           m1_readdatavalid,

    output logic [AW-1:0]  s_address,
    output logic [BCW-1:0] s_burstcount,
    output logic [DW-1:0]  s_writedata,
    output logic [BEW-1:0] s_byteenable,
    output logic           s_write,
    output logic           s_read,
    input  logic           s_waitrequest,
    input  logic [DW-1:0]  s_readdata,
    input  logic           s_readdatavalid,

    output logic           err_orphan
);

    arb_state_t     state_q, state_d;
    logic           owner_q, owner_d;
    logic           last_q, last_d;
    logic [BCW-1:0] wcnt_q, wcnt_d;
    logic [BCW-1:0] rcnt_q;
    logic           orphan_q;

    logic           own_write, own_read, own_wait;
    logic [BCW-1:0] own_bc;
    logic           elig0, elig1, grant;

    logic           rdq_push, rdq_pop, rdq_full, rdq_empty;
    rdq_entry_t     rdq_push_data, rdq_head;
    logic           rd_hit;
    logic [BCW-1:0] rcnt_inc;

    // Owner multiplexer, permanently steering the slave-side payload
    assign own_write    = owner_q ? m1_write      : m0_write;
    assign own_read     = owner_q ? m1_read       : m0_read;
    assign own_bc       = owner_q ? m1_burstcount : m0_burstcount;
    assign s_address    = owner_q ? m1_address    : m0_address;
    assign s_burstcount = own_bc;
    assign s_writedata  = owner_q ? m1_writedata  : m0_writedata;
    assign s_byteenable = owner_q ? m1_byteenable : m0_byteenable;

    // Reads only compete while the return queue has room
    assign elig0 = m0_write | (m0_read & ~rdq_full);
    assign elig1 = m1_write | (m1_read & ~rdq_full);
    assign grant = (elig0 & elig1) ? ~last_q : elig1;

    assign rdq_push_data = rdq_entry_t'{id: owner_q, len: eff_len(own_bc)};

    // Next-state and command-side outputs
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        wcnt_d   = wcnt_q;
        s_write  = 1'b0;
        s_read   = 1'b0;
        own_wait = 1'b1;
        rdq_push = 1'b0;

        case (state_q)
            IDLE: begin
                if (elig0 | elig1) begin
                    owner_d = grant;
                    last_d  = grant;
                    state_d = CMD;
                end
            end
            CMD: begin
                s_write  = own_write;
                s_read   = own_read & ~own_write & ~rdq_full;
                own_wait = s_waitrequest | (own_read & ~own_write & rdq_full);
                if (own_write & ~s_waitrequest) begin
                    if (own_bc <= BCW'(1)) begin
                        state_d = IDLE;
                    end else begin
                        wcnt_d  = own_bc - BCW'(1);
                        state_d = WBURST;
                    end
                end else if (s_read & ~s_waitrequest) begin
                    rdq_push = 1'b1;
                    state_d  = IDLE;
                end else if (~own_read & ~own_write) begin
                    state_d = IDLE;
                end
            end
            WBURST: begin
                // Reads from the owner wait until the burst completes
                s_write  = own_write;
                own_wait = s_waitrequest;
                if (own_write & ~s_waitrequest) begin
                    wcnt_d = wcnt_q - BCW'(1);
                    if (wcnt_q <= BCW'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m0_waitrequest = owner_q ? 1'b1 : own_wait;
    assign m1_waitrequest = owner_q ? own_wait : 1'b1;

    // Read return routing: head of queue names the destination master
    assign rd_hit           = s_readdatavalid & ~rdq_empty;
    assign m0_readdatavalid = rd_hit & ~rdq_head.id;
    assign m1_readdatavalid = rd_hit &  rdq_head.id;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign rcnt_inc         = rcnt_q + BCW'(1);
    assign rdq_pop          = rd_hit & (rcnt_inc >= rdq_head.len);
    assign err_orphan       = orphan_q;

    // State, grant history and beat counters
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= RR_RESET_LAST;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            wcnt_q   <= wcnt_d;
            if (rdq_pop)     rcnt_q <= '0;
            else if (rd_hit) rcnt_q <= rcnt_inc;
            orphan_q <= orphan_q | (s_readdatavalid & rdq_empty);
        end
    end

    sdram_arb_rdq #(
        .DEPTH (MAX_PEND)
    ) u_rdq (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .push      (rdq_push),
        .push_data (rdq_push_data),
        .pop       (rdq_pop),
        .head      (rdq_head),
        .full      (rdq_full),
        .empty     (rdq_empty)
    );

endmodule

// File: tb/tb_sdram_user_arbiter.sv
// Self-checking bench for sdram_user_arbiter: reset values, an arbitration
// vector table, directed multi-cycle sequences, and a randomized two-master
// traffic run scored against transaction-level expectations.
module tb_sdram_user_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic [23:0] m_addr  [2];
    logic [8:0]  m_bc    [2];
    logic [15:0] m_wdata [2];
    logic [1:0]  m_be    [2];
    logic        m_write [2];
    logic        m_read  [2];

    logic        m0_wait, m1_wait, m0_rdv, m1_rdv;
    logic [15:0] m0_rdata, m1_rdata;

    logic [23:0] s_address;
    logic [8:0]  s_burstcount;
    logic [15:0] s_writedata;
    logic [1:0]  s_byteenable;
    logic        s_write, s_read, s_waitrequest;
    logic [15:0] s_readdata;
    logic        s_readdatavalid;
    logic        err_orphan;

    int compared   = 0;
    int mismatched = 0;

    sdram_user_arbiter dut (
        .clk_clk          (clk),
        .reset_reset_n    (rst_n),
        .m0_address       (m_addr[0]),
        .m0_burstcount    (m_bc[0]),
        .m0_writedata     (m_wdata[0]),
        .m0_byteenable    (m_be[0]),
        .m0_write         (m_write[0]),
        .m0_read          (m_read[0]),
        .m0_waitrequest   (m0_wait),
        .m0_readdata      (m0_rdata),
        .m0_readdatavalid (m0_rdv),
        .m1_address       (m_addr[1]),
        .m1_burstcount    (m_bc[1]),
        .m1_writedata     (m_wdata[1]),
        .m1_byteenable    (m_be[1]),
        .m1_write         (m_write[1]),
        .m1_read          (m_read[1]),
        .m1_waitrequest   (m1_wait),
        .m1_readdata      (m1_rdata),
        .m1_readdatavalid (m1_rdv),
        .s_address        (s_address),
        .s_burstcount     (s_burstcount),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_write          (s_write),
        .s_read           (s_read),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid),
        .err_orphan       (err_orphan)
    );

    typedef struct {
        logic w0, r0, w1, r1;
        int   owner;
        logic exp_wr, exp_rd;
    } arb_vec_t;

    typedef struct {
        int          id;
        bit          wr;
        logic [23:0] addr;
        logic [8:0]  bc;
        logic [15:0] data;
    } cmd_t;

    typedef struct {
        int          id;
        logic [15:0] data;
        bit          last;
    } beat_t;

    cmd_t  cmdq[$];    // per-master command stream expected at the slave
    beat_t exp_rd[$];  // per-master read data expected back at the master
    beat_t pend[$];    // slave model: beats still to be returned
    bit    stop;
    int    rd_out;
    int    burst_left, burst_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic wt(input int id);
        return (id == 0) ? m0_wait : m1_wait;
    endfunction

    function automatic logic rdv(input int id);
        return (id == 0) ? m0_rdv : m1_rdv;
    endfunction

    function automatic logic [15:0] rdat(input int id);
        return (id == 0) ? m0_rdata : m1_rdata;
    endfunction

    function automatic int eff(input logic [8:0] bc);
        return (bc == 9'd0) ? 1 : int'(bc);
    endfunction

    function automatic logic [15:0] rd_pat(input logic [23:0] a, input int k);
        return a[15:0] ^ {8'(k), 8'hC3};
    endfunction

    function automatic int find_id(input int id, input bit in_cmd);
        if (in_cmd) begin
            foreach (cmdq[i]) if (cmdq[i].id == id) return i;
        end else begin
            foreach (exp_rd[i]) if (exp_rd[i].id == id) return i;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            m_write[i] = 1'b0;
            m_read[i]  = 1'b0;
            m_addr[i]  = '0;
            m_bc[i]    = 9'd1;
            m_wdata[i] = '0;
            m_be[i]    = 2'b11;
        end
        s_waitrequest   = 1'b0;
        s_readdata      = '0;
        s_readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for the cycle in which master id's request is accepted
    task automatic wait_accept(input int id, input int budget);
        int n;
        n = 0;
        forever begin
            smp();
            if (!wt(id)) break;
            n++;
            if (n > budget) begin
                compared++;
                mismatched++;
                $display("FAIL accept_timeout m%0d: still waiting after %0d cycles", id, n);
                break;
            end
        end
    endtask

    task automatic issue_read(input int id, input logic [23:0] a, input logic [8:0] bc);
        m_read[id] = 1'b1;
        m_addr[id] = a;
        m_bc[id]   = bc;
        wait_accept(id, 20);
        step();
        m_read[id] = 1'b0;
    endtask

    // Random master: builds its expectations, then issues its transactions
    task automatic run_master(input int id, input int ntx);
        bit          wr;
        logic [8:0]  bc;
        logic [23:0] a;
        int          n;
        for (int t = 0; t < ntx; t++) begin
            wr = 1'($urandom_range(0, 1));
            bc = 9'($urandom_range(0, 4));
            a  = {id[0], 7'(t), 16'($urandom)};
            n  = eff(bc);
            if (wr) begin
                for (int b = 0; b < n; b++)
                    cmdq.push_back('{id, 1'b1, a, bc, {id[0], 7'(t), 8'(b)}});
                for (int b = 0; b < n; b++) begin
                    m_write[id] = 1'b1;
                    m_addr[id]  = a;
                    m_bc[id]    = bc;
                    m_wdata[id] = {id[0], 7'(t), 8'(b)};
                    wait_accept(id, 500);
                    step();
                end
                m_write[id] = 1'b0;
            end else begin
                cmdq.push_back('{id, 1'b0, a, bc, 16'h0});
                for (int k = 0; k < n; k++)
                    exp_rd.push_back('{id, rd_pat(a, k), 1'b0});
                m_read[id] = 1'b1;
                m_addr[id] = a;
                m_bc[id]   = bc;
                wait_accept(id, 500);
                step();
                m_read[id] = 1'b0;
            end
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    // Random slave with memory-less return pattern, plus the scoreboards
    task automatic run_slave();
        beat_t cur;
        bit    cur_valid;
        int    id, idx, n;
        while (!stop) begin
            @(posedge clk);
            #1;
            s_waitrequest = ($urandom_range(0, 3) == 0);
            cur_valid = 1'b0;
            if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                cur = pend.pop_front();
                cur_valid = 1'b1;
                s_readdatavalid = 1'b1;
                s_readdata = cur.data;
            end else begin
                s_readdatavalid = 1'b0;
                s_readdata = 16'($urandom);
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rand_route_m%0d", i), 32'(rdv(i)), 32'(cur_valid && cur.id == i));
                if (rdv(i)) begin
                    idx = find_id(i, 1'b0);
                    if (idx < 0) begin
                        chk($sformatf("rand_unexpected_beat_m%0d", i), 32'(rdv(i)), 0);
                    end else begin
                        chk($sformatf("rand_rdata_m%0d", i), 32'(rdat(i)), 32'(exp_rd[idx].data));
                        exp_rd.delete(idx);
                    end
                end
            end
            if (s_write && !s_waitrequest) begin
                id  = int'(s_address[23]);
                idx = find_id(id, 1'b1);
                if (idx < 0) begin
                    chk("rand_unexpected_write", 32'(s_write), 0);
                end else begin
                    chk("rand_wr_kind",  32'(cmdq[idx].wr), 1);
                    chk("rand_wr_addr",  32'(s_address),    32'(cmdq[idx].addr));
                    chk("rand_wr_data",  32'(s_writedata),  32'(cmdq[idx].data));
                    chk("rand_wr_bc",    32'(s_burstcount), 32'(cmdq[idx].bc));
                    cmdq.delete(idx);
                end
                if (burst_left > 0) begin
                    chk("rand_burst_locked", 32'(id), 32'(burst_id));
                    burst_left--;
                end else begin
                    burst_id   = id;
                    burst_left = eff(s_burstcount) - 1;
                end
            end
            if (s_read && !s_waitrequest) begin
                id  = int'(s_address[23]);
                idx = find_id(id, 1'b1);
                chk("rand_read_outside_burst", 32'(burst_left), 0);
                chk("rand_rd_pending_below_4", 32'(rd_out < 4), 1);
                if (idx < 0) begin
                    chk("rand_unexpected_read", 32'(s_read), 0);
                end else begin
                    chk("rand_rd_kind", 32'(cmdq[idx].wr), 0);
                    chk("rand_rd_addr", 32'(s_address),    32'(cmdq[idx].addr));
                    chk("rand_rd_bc",   32'(s_burstcount), 32'(cmdq[idx].bc));
                    cmdq.delete(idx);
                end
                n = eff(s_burstcount);
                for (int k = 0; k < n; k++)
                    pend.push_back('{id, rd_pat(s_address, k), (k == n - 1)});
                rd_out++;
            end
            if (cur_valid && cur.last) rd_out--;
        end
        s_readdatavalid = 1'b0;
        s_waitrequest   = 1'b0;
    endtask

    arb_vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int issued;
        int n;
        int exp_id;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0};

        // Reset values, sampled while reset is held
        clear_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_s_write",    32'(s_write),    0);
        chk("rst_s_read",     32'(s_read),     0);
        chk("rst_m0_wait",    32'(m0_wait),    1);
        chk("rst_m1_wait",    32'(m1_wait),    1);
        chk("rst_m0_rdv",     32'(m0_rdv),     0);
        chk("rst_m1_rdv",     32'(m1_rdv),     0);
        chk("rst_err_orphan", 32'(err_orphan), 0);

        // Arbitration table: first grant after reset
        for (int v = 0; v < 6; v++) begin
            do_reset();
            m_addr[0] = 24'h000111;
            m_addr[1] = 24'h000222;
            m_write[0] = vecs[v].w0;  m_read[0] = vecs[v].r0;
            m_write[1] = vecs[v].w1;  m_read[1] = vecs[v].r1;
            smp();
            chk($sformatf("vec%0d_idle_s_write", v), 32'(s_write), 0);
            step();
            smp();
            chk($sformatf("vec%0d_s_address", v), 32'(s_address),
                (vecs[v].owner == 0) ? 32'h000111 : 32'h000222);
            chk($sformatf("vec%0d_s_write", v), 32'(s_write), 32'(vecs[v].exp_wr));
            chk($sformatf("vec%0d_s_read", v),  32'(s_read),  32'(vecs[v].exp_rd));
            chk($sformatf("vec%0d_owner_wait", v), 32'(wt(vecs[v].owner)), 0);
            chk($sformatf("vec%0d_other_wait", v), 32'(wt(1 - vecs[v].owner)), 1);
            step();
            clear_inputs();
        end

        // Single read of 4 beats routed to m0, then an orphan beat
        do_reset();
        m_read[0] = 1'b1; m_addr[0] = 24'h000100; m_bc[0] = 9'd4;
        step();
        smp();
        chk("p1_s_read",    32'(s_read),       1);
        chk("p1_s_address", 32'(s_address),    32'h000100);
        chk("p1_s_bc",      32'(s_burstcount), 4);
        step();
        m_read[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_readdatavalid = 1'b1;
            s_readdata = 16'(16'h00A0 + k);
            smp();
            chk($sformatf("p1_m0_rdv_%0d", k), 32'(m0_rdv), 1);
            chk($sformatf("p1_m1_rdv_%0d", k), 32'(m1_rdv), 0);
            chk($sformatf("p1_m0_data_%0d", k), 32'(m0_rdata), 32'(16'h00A0 + k));
            chk($sformatf("p1_m1_data_%0d", k), 32'(m1_rdata), 32'(16'h00A0 + k));
            step();
        end
        s_readdatavalid = 1'b1;
        smp();
        chk("p5_orphan_m0_rdv", 32'(m0_rdv), 0);
        chk("p5_orphan_m1_rdv", 32'(m1_rdv), 0);
        step();
        s_readdatavalid = 1'b0;
        smp();
        chk("p5_err_orphan_set", 32'(err_orphan), 1);
        repeat (3) step();
        smp();
        chk("p5_err_orphan_sticky", 32'(err_orphan), 1);

        // Simultaneous single writes: m0 first, one idle cycle, then m1
        do_reset();
        m_write[0] = 1'b1; m_addr[0] = 24'h0000A0;
        m_write[1] = 1'b1; m_addr[1] = 24'h0000B0;
        step();
        smp();
        chk("p2_first_addr", 32'(s_address), 32'h0000A0);
        chk("p2_first_wr",   32'(s_write),   1);
        step();
        m_write[0] = 1'b0;
        smp();
        chk("p2_gap_wr", 32'(s_write), 0);
        step();
        smp();
        chk("p2_second_addr", 32'(s_address), 32'h0000B0);
        chk("p2_second_wr",   32'(s_write),   1);
        step();
        m_write[1] = 1'b0;

        // m1 3-beat write with a stalled second beat while m0 wants to read
        do_reset();
        m_write[1] = 1'b1; m_addr[1] = 24'h000300; m_bc[1] = 9'd3; m_wdata[1] = 16'h1000;
        step();
        m_read[0] = 1'b1; m_addr[0] = 24'h000400; m_bc[0] = 9'd1;
        smp();
        chk("p3_beat0_data", 32'(s_writedata), 32'h1000);
        chk("p3_beat0_m0_wait", 32'(m0_wait), 1);
        step();
        m_wdata[1] = 16'h1001;
        s_waitrequest = 1'b1;
        smp();
        chk("p3_stall_wr",   32'(s_write), 1);
        chk("p3_stall_rd",   32'(s_read),  0);
        chk("p3_stall_m1_wait", 32'(m1_wait), 1);
        step();
        s_waitrequest = 1'b0;
        smp();
        chk("p3_beat1_data", 32'(s_writedata), 32'h1001);
        chk("p3_beat1_m1_wait", 32'(m1_wait), 0);
        step();
        m_wdata[1] = 16'h1002;
        smp();
        chk("p3_beat2_wr",   32'(s_write), 1);
        chk("p3_beat2_data", 32'(s_writedata), 32'h1002);
        chk("p3_beat2_rd",   32'(s_read),  0);
        step();
        m_write[1] = 1'b0;
        smp();
        chk("p3_bubble_wr", 32'(s_write), 0);
        chk("p3_bubble_rd", 32'(s_read),  0);
        step();
        smp();
        chk("p3_read_issued", 32'(s_read),    1);
        chk("p3_read_addr",   32'(s_address), 32'h000400);
        step();
        m_read[0] = 1'b0;
        s_readdatavalid = 1'b1; s_readdata = 16'hBEEF;
        smp();
        chk("p3_ret_m0_rdv", 32'(m0_rdv),   1);
        chk("p3_ret_m1_rdv", 32'(m1_rdv),   0);
        chk("p3_ret_data",   32'(m0_rdata), 32'hBEEF);
        step();
        s_readdatavalid = 1'b0;

        // Queue full: 4 outstanding reads, a fifth stalls until the first pop
        do_reset();
        issue_read(0, 24'h000010, 9'd2);
        issue_read(1, 24'h000020, 9'd2);
        issue_read(0, 24'h000030, 9'd2);
        issue_read(1, 24'h000040, 9'd2);
        m_read[0] = 1'b1; m_addr[0] = 24'h000555; m_bc[0] = 9'd1;
        for (int w = 0; w < 3; w++) begin
            smp();
            chk($sformatf("p4_full_m0_wait_%0d", w), 32'(m0_wait), 1);
            chk($sformatf("p4_full_s_read_%0d", w),  32'(s_read),  0);
            step();
        end
        issued = -1;
        for (int k = 0; k < 8; k++) begin
            exp_id = (k / 2) % 2;
            s_readdatavalid = 1'b1;
            s_readdata = 16'(16'h00C0 + k);
            smp();
            chk($sformatf("p4_route_beat%0d", k), 32'(rdv(exp_id)), 1);
            chk($sformatf("p4_other_beat%0d", k), 32'(rdv(1 - exp_id)), 0);
            chk($sformatf("p4_data_beat%0d", k),  32'(rdat(exp_id)), 32'(16'h00C0 + k));
            if (m_read[0] && !m0_wait && s_read) begin
                issued = k;
                chk("p4_fifth_addr", 32'(s_address), 32'h000555);
            end
            step();
            if (issued == k) m_read[0] = 1'b0;
        end
        chk("p4_fifth_issue_slot", 32'(issued), 3);
        s_readdatavalid = 1'b1; s_readdata = 16'h5555;
        smp();
        chk("p4_fifth_ret_m0", 32'(m0_rdv), 1);
        chk("p4_fifth_ret_m1", 32'(m1_rdv), 0);
        step();
        s_readdatavalid = 1'b0;
        m_read[0] = 1'b0;
        smp();
        chk("p4_no_orphan", 32'(err_orphan), 0);

        // Reset in the middle of a write burst with two reads outstanding
        do_reset();
        issue_read(0, 24'h000010, 9'd1);
        issue_read(1, 24'h000020, 9'd1);
        m_write[0] = 1'b1; m_addr[0] = 24'h000030; m_bc[0] = 9'd4; m_wdata[0] = 16'h3000;
        step();
        step();
        smp();
        chk("p6_in_burst_wr", 32'(s_write), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("p6_rst_s_write", 32'(s_write), 0);
        chk("p6_rst_m0_wait", 32'(m0_wait), 1);
        chk("p6_rst_m1_wait", 32'(m1_wait), 1);
        clear_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        s_readdatavalid = 1'b1;
        smp();
        chk("p6_q_empty_m0_rdv", 32'(m0_rdv), 0);
        chk("p6_q_empty_m1_rdv", 32'(m1_rdv), 0);
        step();
        s_readdatavalid = 1'b0;
        smp();
        chk("p6_q_empty_orphan", 32'(err_orphan), 1);
        step();
        m_write[0] = 1'b1; m_addr[0] = 24'h0000C0;
        m_write[1] = 1'b1; m_addr[1] = 24'h0000D0;
        step();
        smp();
        chk("p6_tie_m0_wins", 32'(s_address), 32'h0000C0);
        step();
        clear_inputs();

        // Randomized two-master traffic against a random slave
        do_reset();
        stop = 1'b0;
        rd_out = 0;
        burst_left = 0;
        burst_id = 0;
        fork
            begin
                fork
                    run_master(0, 25);
                    run_master(1, 25);
                join
                n = 0;
                while ((exp_rd.size() != 0 || pend.size() != 0) && n < 3000) begin
                    @(posedge clk);
                    n++;
                end
                stop = 1'b1;
            end
            run_slave();
        join
        chk("rand_reads_drained",  32'(exp_rd.size()), 0);
        chk("rand_cmds_consumed",  32'(cmdq.size()),   0);
        chk("rand_burst_complete", 32'(burst_left),    0);
        chk("rand_no_orphan",      32'(err_orphan),    0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sdram_user_arbiter.md
Name: sdram_user_arbiter

Overview:
- Two-master Avalon-MM arbiter that shares the single user port of the SDRAM subsystem. That port is 16-bit data, 24-bit word address, 9-bit burstcount and 2-bit byteenable.
- Grants round-robin and locks the grant for the whole write burst.
- Tracks outstanding read bursts in a small queue so each returned beat is routed back to the master that issued it.
- Sits between the application masters and the SDRAM controller's user slave.

Parameters:
- AW, 24, address width (words)
- DW, 16, data width
- BEW, 2, byteenable width (DW/8)
- BCW, 9, burstcount width
- MAX_PEND, 4, maximum outstanding read commands (power of 2)

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- m0_address  in  AW  master 0 word address
- m0_burstcount  in  BCW  master 0 burst length
- m0_writedata  in  DW  master 0 write data
- m0_byteenable  in  BEW  master 0 byte enables
- m0_write  in  1  master 0 write request
- m0_read  in  1  master 0 read request
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  DW  read data (broadcast)
- m0_readdatavalid  out  1  read beat for master 0
- m1_*  same set and directions as m0_*, for master 1
- s_address, s_burstcount, s_writedata, s_byteenable, s_write, s_read  out  as m0  to SDRAM user slave
- s_waitrequest  in  1  slave stall
- s_readdata  in  DW  slave read data
- s_readdatavalid  in  1  slave read beat
- err_orphan  out  1  sticky: readdatavalid arrived with no pending read

Behaviour:
- Reset (async, reset_reset_n=0):
  - state=IDLE; owner cleared; last_grant=1, so m0 wins the first tie.
  - s_read=s_write=0; m0/m1_waitrequest=1; m*_readdatavalid=0.
  - Read queue empty; beat counters 0; err_orphan=0.
  - In-flight reads are discarded.
- States:
  - IDLE: evaluate requests each cycle.
    - A request is eligible if write=1, or if read=1 and the queue is not full.
    - Exactly one eligible master is granted. If both are eligible, the master != last_grant is granted.
    - On grant: owner registered, last_grant updated, go to CMD.
    - No request: remain in IDLE.
  - CMD:
    - s_* = owner's m_* (combinational mux); owner waitrequest = s_waitrequest; non-owner waitrequest = 1.
    - Read accepted (s_read & !s_waitrequest): push {owner, burstcount} to the queue; go to IDLE.
    - Write beat accepted: if burstcount<=1, go to IDLE; else latch wcnt=burstcount-1 and go to WBURST.
    - If the owner drops both read and write, return to IDLE.
  - WBURST:
    - Grant stays locked to the owner; same mux.
    - Each accepted write beat decrements wcnt; the beat taking wcnt to 0 goes to IDLE.
    - Owner read requests during WBURST are not forwarded (s_read=0).
- Arbitration latency: a request first visible in IDLE cycle N appears on s_* in cycle N+1. There is always a 1-cycle bubble between commands.
- burstcount=0 is treated as 1 (both write beats and read return count).
- Read return:
  - Queue head gives id and length.
  - Each s_readdatavalid: m[id]_readdatavalid=1 in the same cycle (combinational); rcnt++.
  - When rcnt reaches the head length: pop and rcnt=0.
  - s_readdata goes to both masters unregistered.
- Queue push and pop in the same cycle are both honoured, with occupancy unchanged.
- Queue full: read requests are ineligible (waitrequest held at 1); writes are still granted.
- s_readdatavalid with the queue empty: no m*_readdatavalid; err_orphan set until reset.
- Counter widths: wcnt and rcnt are BCW bits; queue occupancy is log2(MAX_PEND)+1 bits.

Decomposition:
- Package sdram_arb_pkg:
  - state enum {IDLE, CMD, WBURST}
  - rdq_entry_t struct {logic id; logic [BCW-1:0] len}
  - localparam for the round-robin reset value
- Sub-module sdram_arb_rdq: synchronous FIFO of rdq_entry_t, depth MAX_PEND, with full/empty, same-cycle push/pop, and async reset.

Test Plan:
1. m0 read addr 0x000100 bc=4, slave returns 4 beats 0xA0..0xA3 -> m0_readdatavalid on 4 cycles with that data; m1_readdatavalid stays 0; queue empty afterwards.
2. m0 and m1 both write bc=1 in the same IDLE cycle after reset -> m0 granted first, then m1; s_address sequence m0 then m1, with a 1-cycle gap.
3. m1 write bc=3 with s_waitrequest high on the 2nd beat; m0 reads meanwhile -> 3 m1 beats contiguous on s_*; m0 read issued only after WBURST ends.
4. Issue 4 reads (bc=2) alternating m0/m1 with no returns, then a 5th from m0 -> 5th stalls (m0_waitrequest=1). The 8 returned beats route m0,m0,m1,m1,m0,m0,m1,m1. The 5th read is issued after the first pop.
5. s_readdatavalid pulse with the queue empty -> err_orphan=1 and stays 1; no master readdatavalid.
6. Assert reset_reset_n=0 mid-WBURST with 2 reads pending -> immediately s_write=0, waitrequests=1, queue empty; after release m0 wins a tie.
